// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serial shift sequencing controller.
//   state_e : controller state encoding (idle / shifting / inter-frame gap)
//   eff_len : maps a requested bit count onto the number of bits actually sent
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2
  } state_e;

  // A zero or oversized request means "send the whole word".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned n);
    return ((len == 0) || (len > n)) ? n : len;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Word-in / bit-out bundle of the serial shift sequencing controller.
//   in_data, in_len, in_valid : parallel word offered by the producer
//   in_ready                  : controller accepts a word this cycle
//   s_out, s_en               : serial bit (LSB first) and its qualifier
//   frame_start, done         : pulses on the first / last bit of a frame
//   busy                      : frame or inter-frame gap in progress
// master = producer/observer side, slave = controller side.
interface shift_seq_ctrl_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned LEN_W = 4
);

  logic [N-1:0]     in_data;
  logic [LEN_W-1:0] in_len;
  logic             in_valid;
  logic             in_ready;
  logic             s_out;
  logic             s_en;
  logic             frame_start;
  logic             done;
  logic             busy;

  modport master (
    output in_data,
    output in_len,
    output in_valid,
    input  in_ready,
    input  s_out,
    input  s_en,
    input  frame_start,
    input  done,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_len,
    input  in_valid,
    output in_ready,
    output s_out,
    output s_en,
    output frame_start,
    output done,
    output busy
  );

endinterface

// File: rtl/shift_load_reg.sv
// N-bit right shift register with parallel load.
//   i_clk   : clock, rising edge
//   i_clr_n : synchronous active-low clear (highest priority)
//   i_load  : load i_data (takes priority over shift)
//   i_shift : shift right by one, 0 fill at the MSB
//   i_data  : parallel load value
//   o_ser   : current bit 0
module shift_load_reg #(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [N-1:0] i_data,
  output logic         o_ser
);

  logic [N-1:0] r_sh;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {1'b0, r_sh[N-1:1]};
    end
  end

  assign o_ser = r_sh[0];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencing controller.
// Accepts a word over a valid/ready handshake while idle, shifts out L bits LSB first
// (L = in_len, or N when in_len is 0 or exceeds N), then holds off for GAP cycles.
//   clk   : clock, rising edge
//   reset : synchronous active-low reset; aborts any frame in progress
//   bus   : slave side of shift_seq_ctrl_if (word input, serial output, status)
// Parameters: N word width, LEN_W bit-count width (2**LEN_W must exceed N),
// GAP idle cycles after each frame (0 allowed).
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP   = 2
) (
  input logic             clk,
  input logic             reset,
  shift_seq_ctrl_if.slave bus
);

  // Gap counter needs to hold GAP; keep at least one bit so GAP=0 still elaborates.
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_e           r_state;
  state_e           w_state_next;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_next;
  logic [GW-1:0]    r_gap;
  logic [GW-1:0]    w_gap_next;
  logic             r_first;
  logic             w_first_next;

  logic             w_load;
  logic             w_shift;
  logic             w_ser;
  logic [LEN_W-1:0] w_len_eff;
  logic             w_in_shift;
  logic             w_last_bit;

  assign w_len_eff = LEN_W'(eff_len(32'(bus.in_len), N));

  shift_load_reg #(
    .N (N)
  ) u_shreg (
    .i_clk   (clk),
    .i_clr_n (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (bus.in_data),
    .o_ser   (w_ser)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_gap   <= w_gap_next;
      r_first <= w_first_next;
    end
  end

  assign w_last_bit = (r_cnt == LEN_W'(1));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_gap_next   = r_gap;
    w_first_next = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;

    case (r_state)
      StIdle: begin
        // in_ready is simply "state is idle", so the handshake is just in_valid here.
        if (bus.in_valid) begin
          w_load       = 1'b1;
          w_cnt_next   = w_len_eff;
          w_first_next = 1'b1;
          w_state_next = StShift;
        end
      end

      StShift: begin
        w_shift    = 1'b1;
        w_cnt_next = r_cnt - LEN_W'(1);
        if (w_last_bit) begin
          if (GAP != 0) begin
            w_gap_next   = GW'(GAP);
            w_state_next = StGap;
          end else begin
            w_state_next = StIdle;
          end
        end
      end

      StGap: begin
        w_gap_next = r_gap - GW'(1);
        if (r_gap <= GW'(1)) begin
          w_state_next = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Outputs decode registered state; reset forces them low even before the
  // first clearing edge lands (e.g. reset asserted mid-frame).
  assign w_in_shift = reset && (r_state == StShift);

  assign bus.in_ready    = reset && (r_state == StIdle);
  assign bus.s_en        = w_in_shift;
  assign bus.s_out       = w_in_shift && w_ser;
  assign bus.frame_start = w_in_shift && r_first;
  assign bus.done        = w_in_shift && w_last_bit;
  assign bus.busy        = reset && (r_state != StIdle);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  typedef struct packed {
    logic s_out;
    logic s_en;
    logic fs;
    logic dn;
  } exp_t;

  typedef struct packed {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic [3:0] l;
    logic [5:0] exp;   // {in_ready, s_out, s_en, frame_start, done, busy} of the GAP=2 unit
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.N(8), .LEN_W(4)) bus2 ();
  shift_seq_ctrl_if #(.N(8), .LEN_W(4)) bus0 ();

  shift_seq_ctrl #(.N(8), .LEN_W(4), .GAP(2)) dut2 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus2)
  );

  shift_seq_ctrl #(.N(8), .LEN_W(4), .GAP(0)) dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  // Reference model: each queue lists the outputs of every remaining busy cycle.
  exp_t q2[$];
  exp_t q0[$];
  int   acc2[$];
  int   acc0[$];
  logic bits2[$];
  vec_t tab[$];

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc_n    = 0;
  logic stream_chk = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic push_frame(input int which, input logic [7:0] d, input logic [3:0] l);
    int   len;
    int   gap;
    exp_t e;
    len = ((l == 0) || (l > 8)) ? 8 : int'(l);
    gap = (which == 0) ? 2 : 0;
    for (int i = 0; i < len; i++) begin
      e.s_out = d[i];
      e.s_en  = 1'b1;
      e.fs    = (i == 0);
      e.dn    = (i == len - 1);
      if (which == 0) q2.push_back(e);
      else            q0.push_back(e);
    end
    for (int g = 0; g < gap; g++) begin
      e = '0;
      q2.push_back(e);
    end
  endtask

  function automatic logic [5:0] model_out(input int which);
    exp_t e;
    int   sz;
    if (!rst_n) return 6'b000000;
    sz = (which == 0) ? q2.size() : q0.size();
    if (sz == 0) return 6'b100000;
    e = (which == 0) ? q2[0] : q0[0];
    return {1'b0, e.s_out, e.s_en, e.fs, e.dn, 1'b1};
  endfunction

  // One clock cycle: drive inputs, compare outputs, then advance the model at the edge.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic [3:0] l,
                     input logic use_tab, input logic [5:0] tab_exp, input string tag);
    logic [5:0] obs2;
    logic [5:0] obs0;
    rst_n         = r;
    bus2.in_valid = v;
    bus2.in_data  = d;
    bus2.in_len   = l;
    bus0.in_valid = v;
    bus0.in_data  = d;
    bus0.in_len   = l;
    #2;
    obs2 = {bus2.in_ready, bus2.s_out, bus2.s_en, bus2.frame_start, bus2.done, bus2.busy};
    obs0 = {bus0.in_ready, bus0.s_out, bus0.s_en, bus0.frame_start, bus0.done, bus0.busy};
    chk({tag, "/model_gap2"}, 8'(obs2), 8'(model_out(0)));
    chk({tag, "/model_gap0"}, 8'(obs0), 8'(model_out(1)));
    if (use_tab) chk({tag, "/table"}, 8'(obs2), 8'(tab_exp));
    if (stream_chk && obs0[3]) chk({tag, "/gap0_fs_and_done"}, 8'({obs0[2], obs0[1]}), 8'd3);
    if (v && obs2[5]) acc2.push_back(cyc_n);
    if (v && obs0[5]) acc0.push_back(cyc_n);
    if (obs2[3]) bits2.push_back(obs2[4]);
    @(posedge clk);
    if (!r) begin
      q2.delete();
      q0.delete();
    end else begin
      if (q2.size() == 0) begin
        if (v) push_frame(0, d, l);
      end else begin
        void'(q2.pop_front());
      end
      if (q0.size() == 0) begin
        if (v) push_frame(1, d, l);
      end else begin
        void'(q0.pop_front());
      end
    end
    cyc_n++;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 6'b0, "idle");
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [3:0] l,
                     input logic [5:0] exp);
    vec_t t;
    t.r = 1'b1;
    t.v = v;
    t.d = d;
    t.l = l;
    t.exp = exp;
    tab.push_back(t);
  endtask

  initial begin
    logic [7:0] f1;
    logic [7:0] f2;
    logic [7:0] d;

    // Full word A5, len 0: bits 1,0,1,0,0,1,0,1, two gap cycles, ready on cycle 11.
    add(1'b1, 8'hA5, 4'd0, 6'b100000);
    add(1'b0, 8'hA5, 4'd0, 6'b011101);
    add(1'b0, 8'hA5, 4'd0, 6'b001001);
    add(1'b0, 8'hA5, 4'd0, 6'b011001);
    add(1'b0, 8'hA5, 4'd0, 6'b001001);
    add(1'b0, 8'hA5, 4'd0, 6'b001001);
    add(1'b0, 8'hA5, 4'd0, 6'b011001);
    add(1'b0, 8'hA5, 4'd0, 6'b001001);
    add(1'b0, 8'hA5, 4'd0, 6'b011011);
    add(1'b0, 8'hA5, 4'd0, 6'b000001);
    add(1'b0, 8'hA5, 4'd0, 6'b000001);
    add(1'b0, 8'hA5, 4'd0, 6'b100000);
    // Short frame 06, len 3: bits 0,1,1.
    add(1'b1, 8'h06, 4'd3, 6'b100000);
    add(1'b0, 8'h06, 4'd3, 6'b001101);
    add(1'b0, 8'h06, 4'd3, 6'b011001);
    add(1'b0, 8'h06, 4'd3, 6'b011011);
    add(1'b0, 8'h06, 4'd3, 6'b000001);
    add(1'b0, 8'h06, 4'd3, 6'b000001);
    add(1'b0, 8'h06, 4'd3, 6'b100000);
    // Clamp: len 12 sends exactly 8 ones.
    add(1'b1, 8'hFF, 4'd12, 6'b100000);
    add(1'b0, 8'hFF, 4'd12, 6'b011101);
    for (int i = 0; i < 6; i++) add(1'b0, 8'hFF, 4'd12, 6'b011001);
    add(1'b0, 8'hFF, 4'd12, 6'b011011);
    add(1'b0, 8'hFF, 4'd12, 6'b000001);
    add(1'b0, 8'hFF, 4'd12, 6'b000001);
    add(1'b0, 8'hFF, 4'd12, 6'b100000);

    rst_n = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_len = '0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_len = '0;
    @(posedge clk);
    #2;

    // Reset state, with in_valid offered to show it is ignored.
    cyc(1'b0, 1'b1, 8'h5A, 4'd0, 1'b1, 6'b000000, "reset_state");
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 6'b000000, "reset_state");
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 6'b100000, "first_ready");

    for (int i = 0; i < tab.size(); i++) begin
      cyc(tab[i].r, tab[i].v, tab[i].d, tab[i].l, 1'b1, tab[i].exp, $sformatf("vec%0d", i));
    end
    idle(3);

    // Reset asserted for 3 cycles on bit 4 of a frame.
    cyc(1'b1, 1'b1, 8'hA5, 4'd0, 1'b1, 6'b100000, "rst_accept");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'hA5, 4'd0, 1'b0, 6'b0, "rst_frame");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'hA5, 4'd0, 1'b1, 6'b000000, "rst_low");
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 6'b100000, "rst_release");
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 6'b100000, "rst_quiet");

    // Back-to-back with in_valid held and in_data changed mid-frame.
    acc2.delete();
    bits2.delete();
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, 1'b1, (i < 3) ? 8'h01 : 8'h80, 4'd0, 1'b0, 6'b0, "b2b");
    end
    idle(12);
    chk("b2b_accept_count", 8'(acc2.size()), 8'd2);
    if (acc2.size() >= 2) chk("b2b_accept_spacing", 8'(acc2[1] - acc2[0]), 8'd11);
    chk("b2b_bit_count", 8'(bits2.size()), 8'd16);
    if (bits2.size() >= 16) begin
      for (int i = 0; i < 8; i++) begin
        f1[i] = bits2[i];
        f2[i] = bits2[8 + i];
      end
      chk("b2b_frame1", f1, 8'h01);
      chk("b2b_frame2", f2, 8'h80);
    end

    // Single-bit words streamed: the GAP=0 unit accepts every other cycle.
    acc0.delete();
    stream_chk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      cyc(1'b1, 1'b1, d, 4'd1, 1'b0, 6'b0, "stream");
    end
    stream_chk = 1'b0;
    idle(8);
    chk("stream_accept_count", 8'(acc0.size()), 8'd10);
    for (int i = 1; i < acc0.size(); i++) begin
      chk("stream_accept_spacing", 8'(acc0[i] - acc0[i-1]), 8'd2);
    end

    // Randomized traffic including occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7), 8'($urandom),
          4'($urandom_range(0, 15)), 1'b0, 6'b0, "random");
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
